tick_cascade: RTL and testbench
===============================

Name: tick_cascade

Overview:
- Parametrised multi-stage tick generator, successor to the fixed two-rate divider.
- Stage 0 divides clk_in; each further stage divides the previous stage's wrap event.
- Emits one-cycle tick pulses per stage; these serve as timebases for FSMs, debouncers and display scanning.
- Adds synchronous reset, global enable, phase clear and runtime divider reprogramming with glitch-free (wrap-aligned) update.

Parameters:
- NUM_STAGES, 2, number of cascaded stages (1..8).
- CNT_W, 19, width of every stage counter and divider value.
- DIV_INIT, {19'd1000, 19'd100000}, packed NUM_STAGES*CNT_W reset divider values; stage i occupies bits [i*CNT_W +: CNT_W].

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; when low, all counters hold and no ticks are issued
- sync_clr  in  1  restart phase: counters to 0, pending divider loads applied
- div_load  in  1  one-cycle strobe: write div_value into stage div_sel's shadow register
- div_sel  in  3  target stage index; values >= NUM_STAGES are ignored
- div_value  in  CNT_W  new divider; 0 is treated as 1
- tick  out  NUM_STAGES  registered one-cycle pulse per stage
- busy_load  out  NUM_STAGES  bit i high while stage i has a pending, not-yet-applied load

Behaviour:
- Reset (rst=1 at a clk_in edge):
  - all counters = 0; tick = 0; busy_load = 0.
  - active divider[i] = DIV_INIT[i]; shadow divider[i] = DIV_INIT[i].
  - rst has priority over every other input.
- Wrap events (combinational, internal):
  - wrap[0] = en & (cnt[0] == act_div[0]-1).
  - wrap[i] = wrap[i-1] & (cnt[i] == act_div[i]-1), for i >= 1.
- Counter update:
  - stage 0 increments when en.
  - stage i increments when wrap[i-1].
  - a stage at terminal count that is stepped goes to 0.
- Tick generation:
  - tick[i] <= wrap[i]; latency is one cycle after the wrap cycle.
  - tick[i] period = product of act_div[0..i] clk_in cycles.
  - first tick[0] after rst release with en held high: exactly act_div[0] cycles after release.
  - tick[j] high implies tick[i] high for all i < j in the same cycle.
- Divider 1 (or 0, which is treated as 1): the stage wraps on every input event, so tick[0] is high every cycle while en=1.
- en low: counters and ticks freeze (tick = 0); phase is preserved and counting resumes exactly where it stopped.
- sync_clr=1 (and rst=0):
  - counters = 0; tick = 0 that cycle.
  - every pending shadow value is copied to the active divider; busy_load cleared.
  - sync_clr has priority over en and wrap.
- Runtime load:
  - div_load writes the shadow register and sets busy_load[div_sel] on the next edge.
  - the shadow value is copied to the active divider on that stage's next wrap event, so the current period always completes at the old value.
  - load in the same cycle as a wrap of the target stage: the new value is active for the immediately following period.
  - load arriving while busy: the later value overwrites the shadow register; only the last value is applied.
- A width overflow is impossible: counters compare against act_div-1 and never exceed it.
- A reset asserted mid-period discards phase and any pending loads.

Decomposition:
- Shared include file tick_defs.vh holds:
  - default CNT_W;
  - the standard divider constants (board clock 100 MHz -> 1 kHz = 100000, 1 kHz -> 1 Hz = 1000);
  - a SEL_W = 3 define.
- One sub-module, tick_stage:
  - contents: one counter, active/shadow divider registers and busy flag.
  - inputs: step_in, clr, load.
  - output: wrap_out.
- tick_cascade instantiates NUM_STAGES copies via a generate loop and registers the tick outputs.

Test Plan:
- Setup for all scenarios: NUM_STAGES=3, CNT_W=8, DIV_INIT={2,3,4}.
- Reset release, en=1 for 60 cycles -> tick[0] high on cycles 4, 8, 12, …; tick[1] on cycles 12, 24, …; tick[2] on cycles 24, 48; never more than one cycle wide.
- en low for 5 cycles starting at cycle 6 -> no ticks during the gap; next tick[0] at cycle 13 (phase preserved).
- div_load sel=0, value=2 at cycle 5 -> busy_load[0]=1; tick[0] still at cycle 8; then at 10, 12, 14; busy_load[0]=0 after cycle 8.
- div_value=0 loaded into stage 0, followed by sync_clr -> tick[0] high every cycle while en=1; sync_clr with en=1 gives tick=0 that cycle.
- rst asserted together with sync_clr, div_load and en mid-period -> all outputs 0, active dividers back to {2,3,4}; first tick[0] 4 cycles after release.

Source files
------------

// File: rtl/tick_cascade_pkg.sv
// rtl/tick_cascade_pkg.sv - shared types and constants for the tick cascade
package tick_cascade_pkg;

  localparam int SEL_W         = 3;
  localparam int DEFAULT_CNT_W = 19;
  localparam int DIV_1KHZ      = 100000;
  localparam int DIV_1HZ       = 1000;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/tick_stage.sv
// rtl/tick_stage.sv - one divider stage: counter, active/shadow divider, busy flag
//
// Purpose: counts input events and raises wrap_out combinationally on the
// event that completes a period. A new divider value lands in the shadow
// register and is moved to the active register only at a period boundary
// (wrap) or on a phase clear, so a running period never changes length.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   step_in    - input event (enable for stage 0, lower wrap otherwise)
//   clr        - phase clear; applies the pending divider
//   load       - write load_value into the shadow register
//   load_value - new divider, 0 treated as 1
//   wrap_out   - high in the cycle this stage completes a period
//   busy       - shadow holds a value not yet applied

module tick_stage #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             wrap_out,
  output logic             busy
);

  // A zero divider would never match cnt == div-1 in a useful way, so both
  // the reset value and runtime loads are normalised to at least 1.
  localparam logic [CNT_W-1:0] RST_DIV = (DIV_RST == '0) ? CNT_W'(1) : DIV_RST;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] shadow_div;
  logic [CNT_W-1:0] load_norm;
  logic [CNT_W-1:0] next_shadow;

  assign load_norm   = (load_value == '0) ? CNT_W'(1) : load_value;
  // A load in the same cycle as a wrap or clear is taken straight through,
  // so it governs the very next period.
  assign next_shadow = load ? load_norm : shadow_div;
  assign wrap_out    = step_in && (cnt == act_div - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      act_div    <= RST_DIV;
      shadow_div <= RST_DIV;
      busy       <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      act_div    <= next_shadow;
      shadow_div <= next_shadow;
      busy       <= 1'b0;
    end else begin
      shadow_div <= next_shadow;
      if (step_in) begin
        cnt <= wrap_out ? '0 : cnt + CNT_W'(1);
      end
      if (wrap_out) begin
        act_div <= next_shadow;
        busy    <= 1'b0;
      end else if (load) begin
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_cascade.sv
// rtl/tick_cascade.sv - parametrised cascade of tick dividers with registered pulses
//
// Purpose: stage 0 divides the enabled clock, each later stage divides the
// wrap event of the stage below. tick[i] is the registered wrap of stage i,
// so a higher-stage tick always coincides with every lower-stage tick.
// Ports:
//   clk_in    - system clock
//   rst       - synchronous active-high reset, highest priority
//   en        - count enable; low freezes all counters and ticks
//   sync_clr  - phase restart, applies pending divider loads
//   div_load  - strobe writing div_value into stage div_sel's shadow
//   div_sel   - target stage; values >= NUM_STAGES are ignored
//   div_value - new divider, 0 treated as 1
//   tick      - one-cycle pulse per stage
//   busy_load - per-stage pending-load flag

module tick_cascade
  import tick_cascade_pkg::*;
#(
  parameter int                          NUM_STAGES = 2,
  parameter int                          CNT_W      = DEFAULT_CNT_W,
  parameter logic [NUM_STAGES*CNT_W-1:0] DIV_INIT   = {CNT_W'(DIV_1HZ), CNT_W'(DIV_1KHZ)}
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  div_load,
  input  sel_t                  div_sel,
  input  logic [CNT_W-1:0]      div_value,
  output logic [NUM_STAGES-1:0] tick,
  output logic [NUM_STAGES-1:0] busy_load
);

  // step[0] is the enable; step[i+1] is the wrap of stage i and feeds stage i+1.
  logic [NUM_STAGES:0] step;

  assign step[0] = en;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic stage_load;

    assign stage_load = div_load && (div_sel == SEL_W'(gi));

    tick_stage #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
    ) u_stage (
      .clk        (clk_in),
      .rst        (rst),
      .step_in    (step[gi]),
      .clr        (sync_clr),
      .load       (stage_load),
      .load_value (div_value),
      .wrap_out   (step[gi+1]),
      .busy       (busy_load[gi])
    );
  end

  // A phase clear suppresses any wrap seen in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick <= '0;
    end else if (sync_clr) begin
      tick <= '0;
    end else begin
      tick <= step[NUM_STAGES:1];
    end
  end

endmodule

// File: tb/tb_tick_cascade.sv
// tb/tb_tick_cascade.sv - self-checking bench for tick_cascade
module tb_tick_cascade;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int INIT [N] = '{4, 3, 2};

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          div_load = 1'b0;
  logic [2:0]    div_sel = '0;
  logic [CW-1:0] div_value = '0;
  logic [N-1:0]  tick;
  logic [N-1:0]  busy_load;

  tick_cascade #(
    .NUM_STAGES (N),
    .CNT_W      (CW),
    .DIV_INIT   ({8'd2, 8'd3, 8'd4})
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .sync_clr  (sync_clr),
    .div_load  (div_load),
    .div_sel   (div_sel),
    .div_value (div_value),
    .tick      (tick),
    .busy_load (busy_load)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference: per stage, position within the current period, the period
  // length in force, the value waiting to take over, and a pending flag.
  int       pos  [N];
  int       per  [N];
  int       nxt  [N];
  bit [N-1:0] exp_busy;
  bit [N-1:0] exp_tick;

  task automatic model(input bit r, input bit e, input bit c, input bit l,
                       input int s, input int v);
    int  nv;
    bit  ev;
    bit  w;
    nv = (v == 0) ? 1 : v;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        pos[i] = 0; per[i] = INIT[i]; nxt[i] = INIT[i];
      end
      exp_busy = '0; exp_tick = '0;
    end else if (c) begin
      for (int i = 0; i < N; i++) begin
        if (l && s == i) nxt[i] = nv;
        per[i] = nxt[i]; pos[i] = 0;
      end
      exp_busy = '0; exp_tick = '0;
    end else begin
      ev = e;
      for (int i = 0; i < N; i++) begin
        // Stage i completes a period when it receives an event at the last position.
        w = ev && (pos[i] == per[i] - 1);
        exp_tick[i] = w;
        if (l && s == i) nxt[i] = nv;
        if (ev) pos[i] = w ? 0 : pos[i] + 1;
        if (w) begin
          per[i] = nxt[i]; exp_busy[i] = 1'b0;
        end else if (l && s == i) begin
          exp_busy[i] = 1'b1;
        end
        ev = w;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit l,
                      input int s, input int v, input string tag);
    @(negedge clk_in);
    rst = r; en = e; sync_clr = c; div_load = l;
    div_sel = s[2:0]; div_value = v[CW-1:0];
    model(r, e, c, l, s, v);
    @(posedge clk_in);
    #1;
    checks++;
    assert (tick === exp_tick) else begin
      failures++;
      $error("FAIL %s tick: got %b want %b", tag, tick, exp_tick);
    end
    checks++;
    assert (busy_load === exp_busy) else begin
      failures++;
      $error("FAIL %s busy_load: got %b want %b", tag, busy_load, exp_busy);
    end
  endtask

  int cnt0, cnt1, cnt2, lat;

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 1, 1, 0, 5, "reset_prio");

    // Free run 60 cycles
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int k = 0; k < 60; k++) begin
      step(0, 1, 0, 0, 0, 0, "free_run");
      cnt0 += int'(tick[0]); cnt1 += int'(tick[1]); cnt2 += int'(tick[2]);
    end
    checks++;
    assert (cnt0 == 15 && cnt1 == 5 && cnt2 == 2) else begin
      failures++;
      $error("FAIL free_run_counts: got %0d/%0d/%0d want 15/5/2", cnt0, cnt1, cnt2);
    end

    // Enable gap: en low cycles 6..10, next tick[0] at cycle 13
    step(1, 0, 0, 0, 0, 0, "gap_reset");
    for (int k = 1; k <= 20; k++) begin
      step(0, !(k >= 6 && k <= 10), 0, 0, 0, 0, "en_gap");
      if (k == 13) begin
        checks++;
        assert (tick[0] === 1'b1) else begin
          failures++;
          $error("FAIL en_gap_tick13: got %b want 1", tick[0]);
        end
      end
    end

    // Runtime load sel=0 value=2 at cycle 5
    step(1, 0, 0, 0, 0, 0, "load_reset");
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0, k == 5, 0, 2, "run_load");
      if (k == 6) begin
        checks++;
        assert (busy_load[0] === 1'b1) else begin
          failures++;
          $error("FAIL load_busy: got %b want 1", busy_load[0]);
        end
      end
    end

    // Divider 0 then sync_clr: tick[0] every cycle
    step(0, 1, 0, 1, 0, 0, "load_zero");
    step(0, 1, 1, 0, 0, 0, "clr_with_en");
    cnt0 = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 0, 0, 0, "div_one");
      cnt0 += int'(tick[0]);
    end
    checks++;
    assert (cnt0 == 6) else begin
      failures++;
      $error("FAIL div_one_count: got %0d want 6", cnt0);
    end

    // Mid-period reset with everything asserted
    step(0, 1, 0, 1, 1, 7, "pre_rst");
    step(1, 1, 1, 1, 0, 9, "mid_rst");
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0, 0, 0, 0, "post_rst");
      if (tick[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    assert (lat == 4) else begin
      failures++;
      $error("FAIL first_tick_latency: got %0d want 4", lat);
    end

    // Randomised traffic against the reference
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
